fp16_normalize_round: RTL
=========================

// Module: fp16_normalize_round
// PURPOSE
//  Post-adder stage of the fp16 adder: consumes the aligned significand sum/difference and carry from the CLA,
//  normalises it (1-bit right shift on carry-out, iterative 1-bit/cycle left shift otherwise),
//  rounds to nearest-even and packs a binary16 result with status flags. Valid/ready on both sides.
// PARAMETERS
//  EXP_W  5   exponent field width; bias = 2**(EXP_W-1)-1
//  MAN_W  10  stored fraction width; significand SIG_W = MAN_W+1 (localparam)
// PORTS
//  clk          in   1        clock; all state on rising edge
//  rst_n        in   1        asynchronous active-low reset
//  in_valid     in   1        input operand bundle valid
//  in_ready     out  1        = (state==IDLE) && rst_n
//  sig_sum      in   SIG_W    CLA result R
//  sig_cout     in   1        CLA carry out
//  op_sub       in   1        effective subtract (CLA opCode)
//  exp_in       in   EXP_W    biased exponent of larger operand, 1..30 (subnormal field 0 mapped to 1 upstream)
//  sign_in      in   1        sign of larger-magnitude operand
//  grs_in       in   3        guard/round/sticky bits shifted out by aligner
//  special_in   in   1        NaN/Inf/bypass case resolved upstream
//  special_val  in   16       bypass result
//  out_valid    out  1        result valid; held until out_ready
//  out_ready    in   1        downstream accepts
//  result       out  16       {sign, exp, frac}
//  overflow     out  1        rounded result became Inf
//  underflow    out  1        result subnormal/zero AND inexact
//  inexact      out  1        any nonzero bit discarded, or overflow
// BEHAVIOUR
//  Reset (async): state IDLE; out_valid, result, overflow, underflow, inexact = 0; internal regs 0.
//  FSM: IDLE -> LOAD on accept (in_valid & in_ready); special_in -> DONE directly.
//   NORM: if sig[SIG_W-1]==0 && exp>1 && sig!=0: sig<<=1 (LSB <= g), g<=r, r<=0, s unchanged, exp--; stay.
//         else -> ROUND.  Max 10 shifts.
//   ROUND: RNE, up = g & (r|s|sig[0]); sig+1 carry to 2**SIG_W -> sig=2**MAN_W, exp++. -> DONE.
//   DONE: out_valid=1, outputs stable; out_ready -> IDLE (no back-to-back accept same cycle).
//  Load rules (capture on accept):
//   add & cout: sig={1,sig_sum[SIG_W-1:1]}, grs={sig_sum[0], g, r|s}, exp=exp_in+1.
//   sub & cout: sig=sig_sum, grs=grs_in.   add & !cout: same.
//   sub & !cout (equal exponents only, grs_in==0): sig=(~sig_sum+1), sign inverted, grs=0.
//  Zero: sig==0 && grs==0 after load -> no shifting, result +0 (0x0000), flags 0.
//  Subnormal: NORM exits with exp==1 and sig[SIG_W-1]==0 -> exp field 0; rounding into bit SIG_W-1 yields exp field 1.
//  Overflow: exp>=31 after load or round -> result {sign,5'h1F,10'h0}, overflow=1, inexact=1.
//  Latency: accept cycle t; out_valid at t+3+k (k = shifts); special bypass t+2.
//  Reset mid-operation: discards in-flight op, out_valid drops immediately.
// STRUCTURE
//  fp16_pkg: state_t enum {IDLE,LOAD,NORM,ROUND,DONE}, EXP_W/MAN_W/BIAS, EXP_INF=5'h1F, FP16_PINF, FP16_QNAN.
//  Sub-module fp_round_rne (combinational: sig,grs,exp -> rounded sig,exp,inexact) instanced in ROUND.
// TESTING
//  1.0+1.0: sig_sum=0x000, cout=1, add, exp_in=15, grs=0 -> result 0x4000, flags 0, out_valid at t+3.
//  1.0-0.5: sig_sum=0x200, cout=1, sub, exp_in=15 -> 0x3800 at t+4 (k=1).
//  x-x: sig_sum=0x000, cout=1, sub, exp_in=20, sign_in=1 -> 0x0000, flags 0, t+3.
//  RNE: sig_sum=0x401, add, cout=0, exp_in=15, grs=100 -> 0x3C02 inexact=1; sig_sum=0x400 same grs -> 0x3C00 inexact=1.
//  Overflow: sig_sum=0x7FE, cout=1, add, exp_in=30 -> 0x7C00, overflow=1, inexact=1. Subnormal: sig_sum=0x001, sub, cout=1, exp_in=1 -> 0x0001, underflow=0.
//  Hold out_ready=0 for 5 cycles -> result stable, in_ready=0; pull rst_n low during NORM -> out_valid=0 at once, in_ready=1 after release.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared types and constants for the binary16 adder post-normalisation stage.
package fp16_pkg;
  localparam int FP_EXP_W = 5;
  localparam int FP_MAN_W = 10;
  localparam int BIAS = (1 << (FP_EXP_W - 1)) - 1;
  localparam logic [FP_EXP_W-1:0] EXP_INF = 5'h1F;
  localparam logic [15:0] FP16_PINF = 16'h7C00;
  localparam logic [15:0] FP16_QNAN = 16'h7E00;

  typedef enum logic [2:0] {IDLE, LOAD, NORM, ROUND, DONE} state_t;
endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalised significand with guard/round/sticky bits.
module fp_round_rne
  import fp16_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic [MAN_W:0] sig_i,
  input  logic [2:0]     grs_i,
  input  logic [EXP_W:0] exp_i,
  output logic [MAN_W:0] sig_o,
  output logic [EXP_W:0] exp_o,
  output logic           inexact_o
);
  localparam int SIG_W = MAN_W + 1;

  logic             up;
  logic [SIG_W:0]   sum;

  always_comb begin
    up        = grs_i[2] & (grs_i[1] | grs_i[0] | sig_i[0]);
    sum       = {1'b0, sig_i} + {{SIG_W{1'b0}}, up};
    inexact_o = |grs_i;
    // A carry out of the significand renormalises to 1.000.. with the next exponent
    if (sum[SIG_W]) begin
      sig_o = SIG_W'(1) << MAN_W;
      exp_o = exp_i + (EXP_W + 1)'(1);
    end else begin
      sig_o = sum[SIG_W-1:0];
      exp_o = exp_i;
    end
  end
endmodule

// File: rtl/fp16_normalize_round.sv
// fp16 adder back end: normalise the CLA result one bit per cycle, round RNE, pack with flags.
module fp16_normalize_round
  import fp16_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAN_W:0]   sig_sum,
  input  logic             sig_cout,
  input  logic             op_sub,
  input  logic [EXP_W-1:0] exp_in,
  input  logic             sign_in,
  input  logic [2:0]       grs_in,
  input  logic             special_in,
  input  logic [15:0]      special_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      result,
  output logic             overflow,
  output logic             underflow,
  output logic             inexact
);
  localparam int SIG_W = MAN_W + 1;
  localparam int XW    = EXP_W + 1;
  localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

  state_t            state_q, state_d;
  logic [SIG_W-1:0]  sig_q, sig_d;
  logic [2:0]        grs_q, grs_d;
  logic [XW-1:0]     exp_q, exp_d;
  logic              sign_q, sign_d;
  logic              special_q, special_d;
  logic              zero_q, zero_d;
  logic [15:0]       spec_val_q, spec_val_d;
  logic [15:0]       result_q, result_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              inexact_q, inexact_d;

  logic              accept;
  logic              shift_en;
  logic [SIG_W-1:0]  sig_rnd;
  logic [XW-1:0]     exp_rnd;
  logic              rnd_inexact;

  assign in_ready  = (state_q == IDLE) && rst_n;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign inexact   = inexact_q;

  // Stop at the minimum exponent so the result lands as a subnormal
  assign shift_en = !sig_q[SIG_W-1] && (exp_q > XW'(1)) && (sig_q != '0);

  fp_round_rne #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .sig_i     (sig_q),
    .grs_i     (grs_q),
    .exp_i     (exp_q),
    .sig_o     (sig_rnd),
    .exp_o     (exp_rnd),
    .inexact_o (rnd_inexact)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Specials skip normalisation but still pass through ROUND, where they are packed
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LOAD;
      LOAD:    state_d = special_q ? ROUND : NORM;
      NORM:    if (!shift_en) state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sig_d       = sig_q;
    grs_d       = grs_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    special_d   = special_q;
    zero_d      = zero_q;
    spec_val_d  = spec_val_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    inexact_d   = inexact_q;
    if (accept) begin
      special_d  = special_in;
      spec_val_d = special_val;
      sign_d     = sign_in;
      exp_d      = {1'b0, exp_in};
      sig_d      = sig_sum;
      grs_d      = grs_in;
      if (!op_sub && sig_cout) begin
        sig_d = {1'b1, sig_sum[SIG_W-1:1]};
        grs_d = {sig_sum[0], grs_in[2], grs_in[1] | grs_in[0]};
        exp_d = {1'b0, exp_in} + XW'(1);
      end else if (op_sub && !sig_cout) begin
        // Borrow means the difference is negative: take magnitude, flip sign
        sig_d  = ~sig_sum + SIG_W'(1);
        sign_d = ~sign_in;
        grs_d  = '0;
      end
      zero_d = (sig_d == '0) && (grs_d == '0);
    end else if (state_q == NORM && shift_en) begin
      sig_d = {sig_q[SIG_W-2:0], grs_q[2]};
      grs_d = {grs_q[1], 1'b0, grs_q[0]};
      exp_d = exp_q - XW'(1);
    end else if (state_q == ROUND) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      inexact_d   = 1'b0;
      if (special_q) begin
        result_d = spec_val_q;
      end else if (zero_q) begin
        result_d = 16'h0000;
      end else if (exp_rnd >= EXP_MAX) begin
        result_d   = {sign_q, EXP_INF, {MAN_W{1'b0}}};
        overflow_d = 1'b1;
        inexact_d  = 1'b1;
      end else begin
        result_d    = {sign_q, sig_rnd[SIG_W-1] ? exp_rnd[EXP_W-1:0] : {EXP_W{1'b0}},
                       sig_rnd[MAN_W-1:0]};
        inexact_d   = rnd_inexact;
        underflow_d = !sig_rnd[SIG_W-1] && rnd_inexact;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q       <= '0;
      grs_q       <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      special_q   <= 1'b0;
      zero_q      <= 1'b0;
      spec_val_q  <= '0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      inexact_q   <= 1'b0;
    end else begin
      sig_q       <= sig_d;
      grs_q       <= grs_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      special_q   <= special_d;
      zero_q      <= zero_d;
      spec_val_q  <= spec_val_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      inexact_q   <= inexact_d;
    end
  end
endmodule
